bias_relu: RTL and testbench

- Post-processing stage directly downstream of the gobou multiply-accumulate unit.
- Captures each finished dot product `y` when the controller flags it valid, adds a per-neuron bias fetched from bias RAM, saturates, and applies optional ReLU.
- Emits the result with a write address for the output buffer.
- Counts neurons per layer and pulses `done` with the last output.

---
 rtl/bias_relu_pkg.sv | 17 +
 rtl/sat_relu.sv | 32 +++
 rtl/bias_relu.sv | 137 +++++++++++++
 tb/tb_bias_relu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_relu_pkg.sv
// Shared definitions for the gobou post-processing path.
//   DWIDTH_DEF : default data width of mac output, bias and result (signed fixed point)
//   FRAC_DEF   : default fractional bits (256 = 1.0 at 8)
//   AWIDTH_DEF : default neuron index / address width
//   state_t    : layer sequencer state
package bias_relu_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int FRAC_DEF   = 8;
  localparam int AWIDTH_DEF = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sat_relu.sv
// Combinational saturate-and-ReLU.
//   sum     : (DWIDTH+1)-bit signed pre-saturation value
//   relu_en : clamp negative results to zero when set
//   result  : DWIDTH-bit signed saturated (and optionally rectified) value
module sat_relu
  import bias_relu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic signed [DWIDTH:0]   sum,
  input  logic                     relu_en,
  output logic signed [DWIDTH-1:0] result
);

  // The two top bits disagree exactly when the value does not fit in DWIDTH bits.
  function automatic logic signed [DWIDTH-1:0] saturate(input logic signed [DWIDTH:0] s);
    if (s[DWIDTH] != s[DWIDTH-1]) begin
      return s[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
    end
    return s[DWIDTH-1:0];
  endfunction

  function automatic logic signed [DWIDTH-1:0] relu(input logic signed [DWIDTH-1:0] v,
                                                    input logic en);
    return (en && v[DWIDTH-1]) ? '0 : v;
  endfunction

  always_comb begin
    result = relu(saturate(sum), relu_en);
  end

endmodule

// File: rtl/bias_relu.sv
// Bias add, saturation and optional ReLU on finished mac dot products.
//   clk, xrst          : clock, asynchronous active-high reset
//   start              : one-cycle layer start; latches n_out and relu_en
//   n_out, relu_en     : neuron count and ReLU enable for the layer
//   in_valid, y        : finished accumulation from the mac
//   bias_addr, bias    : bias RAM address (current neuron) and its 1-cycle-late data
//   out_valid, out_addr, out_data : result and output buffer address, 3 cycles after acceptance
//   done               : pulses with the result of neuron n_out-1
module bias_relu
  import bias_relu_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FRAC   = FRAC_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     start,
  input  logic [AWIDTH-1:0]        n_out,
  input  logic                     relu_en,
  input  logic                     in_valid,
  input  logic signed [DWIDTH-1:0] y,
  output logic [AWIDTH-1:0]        bias_addr,
  input  logic signed [DWIDTH-1:0] bias,
  output logic                     out_valid,
  output logic [AWIDTH-1:0]        out_addr,
  output logic signed [DWIDTH-1:0] out_data,
  output logic                     done
);

  if (FRAC >= DWIDTH) begin : g_frac_check
    $error("FRAC must be smaller than DWIDTH");
  end

  state_t              state_q, state_d;
  logic [AWIDTH-1:0]   in_idx;
  logic [AWIDTH-1:0]   n_out_q;
  logic                relu_q;

  logic                start_ok;
  logic [AWIDTH-1:0]   eff_idx;
  logic [AWIDTH-1:0]   eff_n;
  logic                eff_relu;
  logic                accept;
  logic                last;

  logic                    vld_p0, last_p0, relu_p0;
  logic signed [DWIDTH-1:0] y_p0;
  logic [AWIDTH-1:0]       idx_p0;

  logic                    vld_p1, last_p1, relu_p1;
  logic signed [DWIDTH:0]  sum_p1;
  logic [AWIDTH-1:0]       idx_p1;

  logic signed [DWIDTH-1:0] res_p1;

  // A start with a zero neuron count is treated as if it never happened.
  // In a valid start cycle the freshly presented n_out/relu_en and index 0
  // apply to the sample arriving in that same cycle.
  always_comb begin
    start_ok = start && (n_out != '0);
    eff_idx  = start_ok ? '0 : in_idx;
    eff_n    = start_ok ? n_out : n_out_q;
    eff_relu = start_ok ? relu_en : relu_q;
    accept   = in_valid && (start_ok || (state_q == RUN));
    last     = accept && (eff_idx == (eff_n - AWIDTH'(1)));
    state_d  = state_q;
    if (start_ok) state_d = RUN;
    if (last)     state_d = IDLE;
  end

  assign bias_addr = eff_idx;

  // Control and output registers
  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      state_q   <= IDLE;
      in_idx    <= '0;
      n_out_q   <= '0;
      relu_q    <= 1'b0;
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        n_out_q <= n_out;
        relu_q  <= relu_en;
      end
      if (accept)        in_idx <= eff_idx + AWIDTH'(1);
      else if (start_ok) in_idx <= '0;

      // stage 0 -> 1
      vld_p0  <= accept;
      last_p0 <= last;
      // stage 1 -> 2
      vld_p1  <= vld_p0;
      last_p1 <= vld_p0 && last_p0;
      // stage 2 -> output
      out_valid <= vld_p1;
      done      <= vld_p1 && last_p1;
      if (vld_p1) begin
        out_addr <= idx_p1;
        out_data <= res_p1;
      end
    end
  end

  // Data pipeline; carries each sample's own index and ReLU mode so that
  // samples from a restarted layer drain unchanged.
  always_ff @(posedge clk) begin
    // stage 0: capture accepted sample
    if (accept) begin
      y_p0    <= y;
      idx_p0  <= eff_idx;
      relu_p0 <= eff_relu;
    end
    // stage 1: bias arrives from RAM this cycle
    if (vld_p0) begin
      sum_p1  <= (DWIDTH+1)'(y_p0) + (DWIDTH+1)'(bias);
      idx_p1  <= idx_p0;
      relu_p1 <= relu_p0;
    end
  end

  sat_relu #(.DWIDTH(DWIDTH)) u_sat_relu (
    .sum     (sum_p1),
    .relu_en (relu_p1),
    .result  (res_p1)
  );

endmodule

// File: tb/tb_bias_relu.sv
module tb_bias_relu;

  localparam int DW = 16;
  localparam int AW = 10;

  logic                 clk = 1'b0;
  logic                 xrst;
  logic                 start;
  logic [AW-1:0]        n_out;
  logic                 relu_en;
  logic                 in_valid;
  logic signed [DW-1:0] y;
  logic [AW-1:0]        bias_addr;
  logic signed [DW-1:0] bias;
  logic                 out_valid;
  logic [AW-1:0]        out_addr;
  logic signed [DW-1:0] out_data;
  logic                 done;

  logic signed [DW-1:0] bias_mem [0:15];

  int vectors = 0;
  int miscompares = 0;

  bias_relu dut (
    .clk       (clk),
    .xrst      (xrst),
    .start     (start),
    .n_out     (n_out),
    .relu_en   (relu_en),
    .in_valid  (in_valid),
    .y         (y),
    .bias_addr (bias_addr),
    .bias      (bias),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous bias RAM, one cycle read latency
  always @(posedge clk) bias <= bias_mem[bias_addr[3:0]];

  // Single-neuron layer: drive one sample in the start cycle, then wait
  // until just before the result is due (two negedges later).
  task automatic launch_single(input logic signed [DW-1:0] yv,
                               input logic signed [DW-1:0] bv,
                               input logic relu);
    bias_mem[0] = bv;
    @(negedge clk);
    start = 1'b1; n_out = AW'(1); relu_en = relu; in_valid = 1'b1; y = yv;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; y = '0; relu_en = ~relu; n_out = AW'(7);
    @(negedge clk);
  endtask

  task automatic test_reset();
    xrst = 1'b1; start = 1'b0; n_out = '0; relu_en = 1'b0; in_valid = 1'b0; y = '0;
    for (int i = 0; i < 16; i++) bias_mem[i] = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, done, out_addr, out_data, bias_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b done=%0b addr=%0d data=%h baddr=%0d, want all 0",
               out_valid, done, out_addr, out_data, bias_addr);
    end
    xrst = 1'b0;
  endtask

  task automatic test_basic();
    launch_single(16'sh0300, 16'sh0100, 1'b0);
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early: out_valid=%0b before latency, want 0", out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, done, out_addr, out_data} !== {1'b1, 1'b1, 10'd0, 16'h0400}) begin
      miscompares++;
      $display("FAIL basic: got valid=%0b done=%0b addr=%0d data=%h, want 1 1 0 0400",
               out_valid, done, out_addr, out_data);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, done, out_data} !== {1'b0, 1'b0, 16'h0400}) begin
      miscompares++;
      $display("FAIL basic_hold: got valid=%0b done=%0b data=%h, want 0 0 0400",
               out_valid, done, out_data);
    end
  endtask

  task automatic test_relu();
    logic signed [DW-1:0] exp_tab [2];
    exp_tab[0] = 16'sh0000;
    exp_tab[1] = 16'shFC00;
    for (int k = 0; k < 2; k++) begin
      launch_single(-16'sh0500, 16'sh0100, (k == 0));
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[k]) begin
        miscompares++;
        $display("FAIL relu_%0d: got valid=%0b data=%h, want 1 %h",
                 k, out_valid, out_data, exp_tab[k]);
      end
    end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] yt [2];
    logic signed [DW-1:0] bt [2];
    logic signed [DW-1:0] et [2];
    yt[0] = 16'sh7F00; bt[0] = 16'sh0200; et[0] = 16'sh7FFF;
    yt[1] = 16'sh8000; bt[1] = 16'shFF00; et[1] = 16'sh8000;
    for (int k = 0; k < 2; k++) begin
      launch_single(yt[k], bt[k], 1'b0);
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== et[k]) begin
        miscompares++;
        $display("FAIL saturate_%0d: got valid=%0b data=%h, want 1 %h",
                 k, out_valid, out_data, et[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) bias_mem[i] = 16'sh0010;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 6) begin
        vectors++;
        if ({out_valid, done, out_addr, out_data} !==
            {1'b1, (c == 6), AW'(c - 3), DW'((c - 2) * 256 + 16)}) begin
          miscompares++;
          $display("FAIL stream_out_%0d: got valid=%0b done=%0b addr=%0d data=%h, want 1 %0b %0d %h",
                   c - 3, out_valid, done, out_addr, out_data,
                   (c == 6), c - 3, DW'((c - 2) * 256 + 16));
        end
      end else if (c > 6) begin
        vectors++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_drop_%0d: got valid=%0b done=%0b, want 0 0", c, out_valid, done);
        end
      end
      start    = (c == 0);
      n_out    = (c == 0) ? AW'(4) : AW'(1);
      relu_en  = 1'b0;
      in_valid = (c < 5);
      y        = (c < 5) ? DW'((c + 1) * 256) : '0;
      #1;
      if (c < 4) begin
        vectors++;
        if (bias_addr !== AW'(c)) begin
          miscompares++;
          $display("FAIL stream_bias_addr_%0d: got %0d, want %0d", c, bias_addr, c);
        end
      end
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_start_zero();
    int seen;
    seen = 0;
    bias_mem[0] = 16'sh0010;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1 || done === 1'b1) seen++;
      start    = (c == 0);
      n_out    = '0;
      in_valid = (c < 3);
      y        = 16'sh0100;
    end
    start = 1'b0; in_valid = 1'b0;
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL start_zero: got %0d output cycles, want 0", seen);
    end
  endtask

  task automatic test_reset_mid_layer();
    int seen;
    for (int i = 0; i < 4; i++) bias_mem[i] = 16'sh0010;
    @(negedge clk);
    start = 1'b1; n_out = AW'(4); relu_en = 1'b0; in_valid = 1'b1; y = 16'sh0700;
    @(negedge clk);
    start = 1'b0; y = 16'sh0800;
    @(negedge clk);
    in_valid = 1'b0;
    xrst = 1'b1;
    #1;
    vectors++;
    if ({out_valid, done, out_addr, out_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%0b done=%0b addr=%0d data=%h, want 0 0 0 0000",
               out_valid, done, out_addr, out_data);
    end
    repeat (2) @(negedge clk);
    xrst = 1'b0;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_stale: got %0d stale outputs, want 0", seen);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 3 || c == 4) begin
        vectors++;
        if ({out_valid, done, out_addr, out_data} !==
            {1'b1, (c == 4), AW'(c - 3), DW'((c - 2) * 256 + 16)}) begin
          miscompares++;
          $display("FAIL reset_restart_%0d: got valid=%0b done=%0b addr=%0d data=%h, want 1 %0b %0d %h",
                   c - 3, out_valid, done, out_addr, out_data,
                   (c == 4), c - 3, DW'((c - 2) * 256 + 16));
        end
      end
      start    = (c == 0);
      n_out    = AW'(2);
      in_valid = (c < 2);
      y        = DW'((c + 1) * 256);
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_saturation();
    test_back_to_back();
    test_start_zero();
    test_reset_mid_layer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
